// File: rtl/prbs_checker.sv
// Self-synchronising serial checker for maximal-length LFSR streams.
// Optional PRBS_CHK_FLYWHEEL_EN: free-running reference predictor while locked.
module prbs_checker #(
    parameter int WIDTH        = 4,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 8,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
    output logic [ERR_W-1:0] err_count
);

    function automatic logic [31:0] taps_f(input int w);
        case (w)
            2:       return 32'h3;
            3:       return 32'h5;
            4:       return 32'h9;
            5:       return 32'h12;
            6:       return 32'h21;
            7:       return 32'h41;
            8:       return 32'h8E;
            9:       return 32'h108;
            10:      return 32'h204;
            11:      return 32'h402;
            12:      return 32'h829;
            13:      return 32'h100D;
            14:      return 32'h2015;
            15:      return 32'h4001;
            16:      return 32'h8016;
            17:      return 32'h10004;
            18:      return 32'h20040;
            19:      return 32'h40013;
            20:      return 32'h80004;
            21:      return 32'h100002;
            22:      return 32'h200001;
            23:      return 32'h400010;
            24:      return 32'h80000D;
            25:      return 32'h1000004;
            26:      return 32'h2000023;
            27:      return 32'h4000013;
            28:      return 32'h8000004;
            29:      return 32'h10000002;
            30:      return 32'h20000029;
            31:      return 32'h40000004;
            32:      return 32'h80000062;
            default: return 32'h0;
        endcase
    endfunction

    localparam logic [31:0]      TAPS_ALL = taps_f(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam int               FW       = $clog2(WIDTH + 1);
    localparam int               MW       = $clog2(LOCK_COUNT + 1);
    localparam int               BW       = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_n;
    logic [FW-1:0]    r_fill;
    logic [FW-1:0]    w_fill_n;
    logic [MW-1:0]    r_match;
    logic [MW-1:0]    w_match_n;
    logic [BW-1:0]    r_bad;
    logic [BW-1:0]    w_bad_n;
    logic             r_locked;
    logic             w_locked_n;
    logic             r_pulse;
    logic             w_pulse_n;
    logic             r_loss;
    logic             w_loss_n;
    logic [ERR_W-1:0] r_err;
    logic             w_err_inc;
    logic             w_pred;
    logic             w_match;
    logic             w_lk_match;

    assign w_shreg_n = {r_shreg[WIDTH-2:0], in_bit};
    assign w_pred    = ^(r_shreg & TAPS);
    // An all-zero history predicts zero forever; never trust it.
    assign w_match   = (in_bit == w_pred) && (r_shreg != '0);

`ifdef PRBS_CHK_FLYWHEEL_EN
    logic [WIDTH-1:0] r_ref;
    logic             w_ref_pred;
    logic             w_load_ref;
    logic             w_adv_ref;

    assign w_ref_pred = ^(r_ref & TAPS);
    assign w_lk_match = (in_bit == w_ref_pred) && (r_ref != '0);
`else
    assign w_lk_match = w_match;
`endif

    always_comb begin
        w_state_n  = r_state;
        w_fill_n   = r_fill;
        w_match_n  = r_match;
        w_bad_n    = r_bad;
        w_locked_n = r_locked;
        w_pulse_n  = 1'b0;
        w_loss_n   = 1'b0;
        w_err_inc  = 1'b0;
`ifdef PRBS_CHK_FLYWHEEL_EN
        w_load_ref = 1'b0;
        w_adv_ref  = 1'b0;
`endif
        if (en) begin
            case (r_state)
                SEARCH: begin
                    if (r_fill == FW'(WIDTH - 1)) begin
                        w_state_n = VERIFY;
                        w_fill_n  = '0;
                        w_match_n = '0;
                    end else begin
                        w_fill_n = r_fill + FW'(1);
                    end
                end
                VERIFY: begin
                    if (!w_match) begin
                        w_match_n = '0;
                    end else if (r_match == MW'(LOCK_COUNT - 1)) begin
                        w_state_n  = LOCKED;
                        w_match_n  = '0;
                        w_bad_n    = '0;
                        w_locked_n = 1'b1;
`ifdef PRBS_CHK_FLYWHEEL_EN
                        w_load_ref = 1'b1;
`endif
                    end else begin
                        w_match_n = r_match + MW'(1);
                    end
                end
                LOCKED: begin
`ifdef PRBS_CHK_FLYWHEEL_EN
                    w_adv_ref = 1'b1;
`endif
                    if (w_lk_match) begin
                        w_bad_n = '0;
                    end else begin
                        w_pulse_n = 1'b1;
                        w_err_inc = 1'b1;
                        if (r_bad == BW'(UNLOCK_COUNT - 1)) begin
                            w_state_n  = SEARCH;
                            w_fill_n   = '0;
                            w_bad_n    = '0;
                            w_locked_n = 1'b0;
                            w_loss_n   = 1'b1;
                        end else begin
                            w_bad_n = r_bad + BW'(1);
                        end
                    end
                end
                default: w_state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SEARCH;
            r_shreg  <= '0;
            r_fill   <= '0;
            r_match  <= '0;
            r_bad    <= '0;
            r_locked <= 1'b0;
            r_pulse  <= 1'b0;
            r_loss   <= 1'b0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_fill   <= w_fill_n;
            r_match  <= w_match_n;
            r_bad    <= w_bad_n;
            r_locked <= w_locked_n;
            r_pulse  <= w_pulse_n;
            r_loss   <= w_loss_n;
            if (en) begin
                r_shreg <= w_shreg_n;
            end
            if (clear) begin
                r_err <= '0;
            end else if (w_err_inc && (r_err != '1)) begin
                r_err <= r_err + ERR_W'(1);
            end
        end
    end

`ifdef PRBS_CHK_FLYWHEEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref <= '0;
        end else if (w_load_ref) begin
            r_ref <= w_shreg_n;
        end else if (w_adv_ref) begin
            r_ref <= {r_ref[WIDTH-2:0], w_ref_pred};
        end
    end
`endif

    assign locked    = r_locked;
    assign err_pulse = r_pulse;
    assign sync_loss = r_loss;
    assign err_count = r_err;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: lock vector table, directed corners, and a
// randomized stream compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_prbs_checker;

    localparam int W        = 4;
    localparam int LOCK_N   = 16;
    localparam int UNLOCK_N = 8;
    localparam int ERR_MAX  = 65535;
`ifdef PRBS_CHK_FLYWHEEL_EN
    localparam int EXP_SINGLE = 1;
`else
    localparam int EXP_SINGLE = 3;
`endif

    logic        clk = 1'b0;
    logic        reset, en, in_bit, clear;
    logic        locked, err_pulse, sync_loss;
    logic [15:0] err_count;
    logic        s_reset, s_en, s_bit, s_clr;
    logic        s_locked, s_pulse, s_loss;
    logic [3:0]  s_err;

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH(4), .LOCK_COUNT(16), .UNLOCK_COUNT(8), .ERR_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .en(en), .in_bit(in_bit),
        .clear(clear), .locked(locked), .err_pulse(err_pulse),
        .sync_loss(sync_loss), .err_count(err_count)
    );

    prbs_checker #(
        .WIDTH(4), .LOCK_COUNT(16), .UNLOCK_COUNT(32), .ERR_W(4)
    ) u_sat (
        .clk(clk), .reset(s_reset), .en(s_en), .in_bit(s_bit),
        .clear(s_clr), .locked(s_locked), .err_pulse(s_pulse),
        .sync_loss(s_loss), .err_count(s_err)
    );

    typedef struct {
        logic        e;
        logic        b;
        logic        c;
        logic        xl;
        logic        xp;
        logic        xs;
        logic [15:0] xe;
    } vec_t;

    vec_t       tbl[24];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pulse, n_loss;
    logic [3:0] taps_v = 4'h9;
    logic [3:0] g;
    logic [3:0] s_sh;

    // Reference model: accepted-bit history, phase 0/1/2 = fill/verify/locked.
    bit m_hist[$];
    bit m_ref[$];
    int m_phase, m_fill, m_run, m_bad, m_err;
    bit m_lock, m_pulse, m_loss;

    function automatic logic gen_next();
        logic nb;
        nb = ^(g & taps_v);
        g  = {g[2:0], nb};
        return nb;
    endfunction

    function automatic bit hist_pred();
        bit x = 1'b0;
        for (int i = 0; i < W; i++)
            if (taps_v[i] && m_hist.size() > i)
                x ^= m_hist[m_hist.size() - 1 - i];
        return x;
    endfunction

    function automatic bit hist_nz();
        bit x = 1'b0;
        foreach (m_hist[i]) x |= m_hist[i];
        return x;
    endfunction

    function automatic bit ref_pred();
        bit x = 1'b0;
        for (int i = 0; i < W; i++)
            if (taps_v[i] && m_ref.size() > i)
                x ^= m_ref[m_ref.size() - 1 - i];
        return x;
    endfunction

    function automatic bit ref_nz();
        bit x = 1'b0;
        foreach (m_ref[i]) x |= m_ref[i];
        return x;
    endfunction

    function automatic bit lock_pred();
`ifdef PRBS_CHK_FLYWHEEL_EN
        return ref_pred();
`else
        return hist_pred();
`endif
    endfunction

    task automatic model_edge(input logic e, input logic b,
                              input logic c, input logic r);
        bit p, nz, load;
        m_pulse = 1'b0;
        m_loss  = 1'b0;
        load    = 1'b0;
        if (r) begin
            m_hist.delete();
            m_ref.delete();
            m_phase = 0; m_fill = 0; m_run = 0;
            m_bad = 0; m_err = 0; m_lock = 1'b0;
            return;
        end
        if (e) begin
            p  = hist_pred();
            nz = hist_nz();
            if (m_phase == 0) begin
                m_fill++;
                if (m_fill == W) begin
                    m_phase = 1;
                    m_run   = 0;
                end
            end else if (m_phase == 1) begin
                if (b == p && nz) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_phase = 2;
                        m_lock  = 1'b1;
                        m_bad   = 0;
                        load    = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
`ifdef PRBS_CHK_FLYWHEEL_EN
                p  = ref_pred();
                nz = ref_nz();
                m_ref.push_back(p);
                void'(m_ref.pop_front());
`endif
                if (b == p && nz) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_err < ERR_MAX) m_err++;
                    m_bad++;
                    if (m_bad == UNLOCK_N) begin
                        m_phase = 0;
                        m_fill  = 0;
                        m_bad   = 0;
                        m_lock  = 1'b0;
                        m_loss  = 1'b1;
                    end
                end
            end
            m_hist.push_back(b);
            if (m_hist.size() > W) void'(m_hist.pop_front());
            if (load) m_ref = m_hist;
        end
        if (c) m_err = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic b, input logic c);
        en = e; in_bit = b; clear = c;
        @(posedge clk);
        model_edge(e, b, c, reset);
        #1;
        check("outputs",
              {13'd0, locked, err_pulse, sync_loss, err_count},
              {13'd0, m_lock, m_pulse, m_loss, m_err[15:0]});
        n_pulse += int'(err_pulse);
        n_loss  += int'(sync_loss);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic s_step(input logic e, input logic b, input logic c);
        s_en = e; s_bit = b; s_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic b, e, c;
        int   n, acc, cyc;
        reset = 1'b1; en = 1'b0; in_bit = 1'b0; clear = 1'b0;
        s_reset = 1'b1; s_en = 1'b0; s_bit = 1'b0; s_clr = 1'b0;
        n_pulse = 0; n_loss = 0;

        g = 4'h1;
        for (int i = 0; i < 24; i++) begin
            tbl[i].e  = 1'b1;
            tbl[i].b  = gen_next();
            tbl[i].c  = 1'b0;
            tbl[i].xl = (i >= 19);
            tbl[i].xp = 1'b0;
            tbl[i].xs = 1'b0;
            tbl[i].xe = 16'd0;
        end

        do_reset();
        check("reset_state", {13'd0, locked, err_pulse, sync_loss, err_count}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].e, tbl[i].b, tbl[i].c);
            check("lock_vec",
                  {13'd0, locked, err_pulse, sync_loss, err_count},
                  {13'd0, tbl[i].xl, tbl[i].xp, tbl[i].xs, tbl[i].xe});
        end

        for (int i = 0; i < 100; i++) step(1'b1, gen_next(), 1'b0);
        check("clean_err", 32'(err_count), 32'd0);

        n_pulse = 0;
        step(1'b1, ~gen_next(), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, gen_next(), 1'b0);
        check("single_err", 32'(err_count), EXP_SINGLE);
        check("single_pulses", n_pulse, EXP_SINGLE);
        check("single_locked", 32'(locked), 32'd1);

        n_loss = 0;
        for (int i = 0; i < 8; i++) step(1'b1, ~lock_pred(), 1'b0);
        check("loss_pulses", n_loss, 1);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_err", 32'(err_count), EXP_SINGLE + 8);
        n = 0;
        while (!locked && n < 60) begin
            step(1'b1, gen_next(), 1'b0);
            n++;
        end
        check("relock_bits", n, 20);

        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
        check("dead_locked", 32'(locked), 32'd0);
        check("dead_err", 32'(err_count), 32'd0);

        do_reset();
        acc = 0; cyc = 0;
        while (!locked && cyc < 400) begin
            e = ($urandom_range(0, 2) != 0);
            b = e ? gen_next() : 1'($urandom_range(0, 1));
            step(e, b, 1'b0);
            if (e) acc++;
            cyc++;
        end
        check("gap_lock_bits", acc, 20);

        step(1'b1, ~gen_next(), 1'b1);
        check("clear_wins", 32'(err_count), 32'd0);

        for (int i = 0; i < 500; i++) begin
            e = ($urandom_range(0, 3) != 0);
            b = e ? gen_next() : 1'b0;
            if (e && $urandom_range(0, 39) == 0) b = ~b;
            c = ($urandom_range(0, 49) == 0);
            step(e, b, c);
        end

        cyc = 0;
        while (!locked && cyc < 100) begin
            step(1'b1, gen_next(), 1'b0);
            cyc++;
        end
        check("pre_reset_locked", 32'(locked), 32'd1);
        reset = 1'b1;
        step(1'b1, gen_next(), 1'b0);
        reset = 1'b0;
        check("reset_outs", {13'd0, locked, err_pulse, sync_loss, err_count}, 32'd0);
        n = 0;
        while (!locked && n < 60) begin
            step(1'b1, gen_next(), 1'b0);
            n++;
        end
        check("reset_relock_bits", n, 20);

        en = 1'b0;
        s_reset = 1'b1;
        s_step(1'b0, 1'b0, 1'b0);
        s_reset = 1'b0;
        check("sat_reset", {27'd0, s_locked, s_err}, 32'd0);
        g = 4'h1;
        s_sh = 4'h0;
        for (int i = 0; i < 20; i++) begin
            b = gen_next();
            s_sh = {s_sh[2:0], b};
            s_step(1'b1, b, 1'b0);
        end
        check("sat_locked", 32'(s_locked), 32'd1);
        for (int i = 0; i < 20; i++) begin
`ifdef PRBS_CHK_FLYWHEEL_EN
            b = ~gen_next();
`else
            b = ~(^(s_sh & taps_v));
`endif
            s_sh = {s_sh[2:0], b};
            s_step(1'b1, b, 1'b0);
        end
        check("sat_err", 32'(s_err), 32'd15);
        check("sat_still_locked", 32'(s_locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
